// File: rtl/ut_stream_sequencer_pkg.sv
// Shared types and widths for the Ut-row projection sequencer.
package fofb_seq_pkg;

    localparam int UT_AW = 9;
    localparam int OVR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_WAIT
    } seq_state_t;

    // Ut row addressing wraps modulo the DPRAM depth.
    function automatic logic [UT_AW-1:0] ut_addr(input logic [UT_AW-1:0] base,
                                                 input logic [UT_AW-1:0] idx);
        return UT_AW'(base + idx);
    endfunction

endpackage

// File: rtl/ut_stream_sequencer_if.sv
// Read-side bus towards the Ut DPRAM / error buffer and the operand stream into the MAC chain.
interface ut_stream_sequencer_if;
    import fofb_seq_pkg::*;

    logic [UT_AW-1:0] ut_ramRdAddr;
    logic             ut_outValid;
    logic [UT_AW-1:0] pos_rdAddr;
    logic             pos_rdEn;
    logic             s_ut_tvalid_t;
    logic             posError_tvalid;
    logic             posError_tlast;
    logic             eigen_update_trig;

    modport master (
        output ut_ramRdAddr, ut_outValid, pos_rdAddr, pos_rdEn,
        output s_ut_tvalid_t, posError_tvalid, posError_tlast,
        input  eigen_update_trig
    );

    modport slave (
        input  ut_ramRdAddr, ut_outValid, pos_rdAddr, pos_rdEn,
        input  s_ut_tvalid_t, posError_tvalid, posError_tlast,
        output eigen_update_trig
    );

endinterface

// File: rtl/ut_stream_sequencer.sv
// Sequences one Ut-row projection pass: issues reads, aligns tvalid/tlast to the read
// latency, then waits for the eigen update strobe with timeout and overrun accounting.
module ut_stream_sequencer
    import fofb_seq_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                 sysClk,
    input  logic                 sysRst_n,
    input  logic                 trig,
    input  logic                 seq_enable,
    input  logic [UT_AW-1:0]     elem_count,
    input  logic [UT_AW-1:0]     ut_base,
    ut_stream_sequencer_if.master dp,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [OVR_W-1:0]     overrun_cnt
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FL_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(RD_LAT - 1);

    seq_state_t         state_reg, state_next;
    logic [UT_AW-1:0]   n_last_reg, n_last_next;
    logic [UT_AW-1:0]   base_reg, base_next;
    logic [UT_AW-1:0]   idx_reg, idx_next, idx_inc;
    logic [UT_AW-1:0]   addr_reg, addr_next;
    logic               ut_en_reg, ut_en_next;
    logic               last_reg, last_next;
    logic [FL_W-1:0]    fl_cnt_reg, fl_cnt_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic               done_reg, done_next;
    logic               terr_reg, terr_next;
    logic [OVR_W-1:0]   ovr_reg, ovr_next;

    // Issue-enable / last-flag delay line; tap 0 is the issue stage itself.
    logic [RD_LAT-1:0]  vld_sr_reg, last_sr_reg;
    logic [RD_LAT:0]    vld_tap, last_tap;

    assign vld_tap  = {vld_sr_reg, ut_en_reg};
    assign last_tap = {last_sr_reg, last_reg};

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_reg   <= S_IDLE;
            n_last_reg  <= '0;
            base_reg    <= '0;
            idx_reg     <= '0;
            addr_reg    <= '0;
            ut_en_reg   <= 1'b0;
            last_reg    <= 1'b0;
            fl_cnt_reg  <= '0;
            tmo_cnt_reg <= '0;
            done_reg    <= 1'b0;
            terr_reg    <= 1'b0;
            ovr_reg     <= '0;
            vld_sr_reg  <= '0;
            last_sr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            n_last_reg  <= n_last_next;
            base_reg    <= base_next;
            idx_reg     <= idx_next;
            addr_reg    <= addr_next;
            ut_en_reg   <= ut_en_next;
            last_reg    <= last_next;
            fl_cnt_reg  <= fl_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            done_reg    <= done_next;
            terr_reg    <= terr_next;
            ovr_reg     <= ovr_next;
            vld_sr_reg  <= vld_tap[RD_LAT-1:0];
            last_sr_reg <= last_tap[RD_LAT-1:0];
        end
    end

    always_comb begin
        state_next   = state_reg;
        n_last_next  = n_last_reg;
        base_next    = base_reg;
        idx_next     = idx_reg;
        addr_next    = addr_reg;
        ut_en_next   = 1'b0;
        last_next    = 1'b0;
        fl_cnt_next  = fl_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        done_next    = 1'b0;
        terr_next    = terr_reg;
        ovr_next     = ovr_reg;
        idx_inc      = idx_reg + UT_AW'(1);

        // Any trig outside IDLE is an overrun, including one coincident with completion.
        if (trig && (state_reg != S_IDLE) && (ovr_reg != '1))
            ovr_next = ovr_reg + OVR_W'(1);

        case (state_reg)
            S_IDLE: begin
                if (trig && seq_enable) begin
                    state_next  = S_ISSUE;
                    n_last_next = elem_count;
                    base_next   = ut_base;
                    idx_next    = '0;
                    addr_next   = ut_base;
                    ut_en_next  = 1'b1;
                    last_next   = (elem_count == '0);
                    terr_next   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (idx_reg == n_last_reg) begin
                    state_next   = S_FLUSH;
                    fl_cnt_next  = '0;
                    tmo_cnt_next = '0;
                end else begin
                    idx_next   = idx_inc;
                    addr_next  = ut_addr(base_reg, idx_inc);
                    ut_en_next = 1'b1;
                    last_next  = (idx_inc == n_last_reg);
                end
            end
            S_FLUSH: begin
                if (fl_cnt_reg == FL_LAST) begin
                    state_next   = S_WAIT;
                    tmo_cnt_next = '0;
                end else begin
                    fl_cnt_next = fl_cnt_reg + FL_W'(1);
                end
            end
            S_WAIT: begin
                if (dp.eigen_update_trig) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    terr_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dp.ut_ramRdAddr    = addr_reg;
    assign dp.ut_outValid     = ut_en_reg;
    assign dp.pos_rdAddr      = idx_reg;
    assign dp.pos_rdEn        = ut_en_reg;
    assign dp.s_ut_tvalid_t   = vld_tap[RD_LAT];
    assign dp.posError_tvalid = vld_tap[RD_LAT];
    assign dp.posError_tlast  = last_tap[RD_LAT];

    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign timeout_err = terr_reg;
    assign overrun_cnt = ovr_reg;

endmodule

// File: tb/tb_ut_stream_sequencer.sv
// Self-checking bench: directed pass table, hand-written corner sequences and random traffic
// compared cycle by cycle against a timeline model of a pass.
module tb_ut_stream_sequencer;
    import fofb_seq_pkg::*;

    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 16;
    localparam int INF     = 32'h3fff_ffff;

    logic        sysClk = 1'b0;
    logic        sysRst_n = 1'b0;
    logic        trig = 1'b0;
    logic        seq_enable = 1'b0;
    logic [8:0]  elem_count = '0;
    logic [8:0]  ut_base = '0;
    logic        busy, done, timeout_err;
    logic [15:0] overrun_cnt;

    ut_stream_sequencer_if dp_if();

    ut_stream_sequencer #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .sysClk      (sysClk),
        .sysRst_n    (sysRst_n),
        .trig        (trig),
        .seq_enable  (seq_enable),
        .elem_count  (elem_count),
        .ut_base     (ut_base),
        .dp          (dp_if),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 sysClk = ~sysClk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Pass timeline model: a pass accepted in cycle T with n = elem_count.
    bit m_act;
    int m_T, m_n, m_b, m_end;
    bit m_terr, m_done;
    int m_ovr;

    // Per-pass observations for the table checks.
    int o_beats, o_tl, o_tl_idx, o_done, o_done_off, o_terr_off, t0;
    int o_a[$];
    int o_p[$];

    typedef struct {
        int elem; int base; int eig;
        int beats; int a0; int alast; int dn; int terr; int terr_off;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_act = 1'b0; m_end = INF; m_terr = 1'b0; m_done = 1'b0; m_ovr = 0;
    endtask

    task automatic obs_clear();
        o_beats = 0; o_tl = 0; o_tl_idx = -1; o_done = 0; o_done_off = -1; o_terr_off = -1;
        o_a.delete(); o_p.delete();
        t0 = cyc;
    endtask

    task automatic compare();
        int rel;
        bit e_uv, e_tv, e_tl, e_busy;
        rel    = cyc - m_T;
        e_uv   = m_act && rel >= 1 && rel <= 1 + m_n;
        e_tv   = m_act && rel >= 1 + RD_LAT && rel <= 1 + RD_LAT + m_n;
        e_tl   = m_act && rel == 1 + RD_LAT + m_n;
        e_busy = m_act && rel >= 1 && cyc < m_end;
        chk("ut_outValid", int'(dp_if.ut_outValid), int'(e_uv));
        chk("pos_rdEn", int'(dp_if.pos_rdEn), int'(e_uv));
        chk("s_ut_tvalid_t", int'(dp_if.s_ut_tvalid_t), int'(e_tv));
        chk("posError_tvalid", int'(dp_if.posError_tvalid), int'(e_tv));
        chk("posError_tlast", int'(dp_if.posError_tlast), int'(e_tl));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(m_done));
        chk("timeout_err", int'(timeout_err), int'(m_terr));
        chk("overrun_cnt", int'(overrun_cnt), m_ovr);
        if (e_uv) begin
            chk("ut_ramRdAddr", int'(dp_if.ut_ramRdAddr), (m_b + rel - 1) % 512);
            chk("pos_rdAddr", int'(dp_if.pos_rdAddr), rel - 1);
        end
        if (dp_if.s_ut_tvalid_t) o_beats++;
        if (dp_if.posError_tlast) begin o_tl++; o_tl_idx = o_beats - 1; end
        if (dp_if.ut_outValid) begin
            o_a.push_back(int'(dp_if.ut_ramRdAddr));
            o_p.push_back(int'(dp_if.pos_rdAddr));
        end
        if (done) begin o_done++; o_done_off = cyc - t0; end
        if (timeout_err && cyc > t0 && o_terr_off < 0) o_terr_off = cyc - t0;
    endtask

    task automatic m_update(input bit tr, input bit en, input bit eg, input int ec, input int ub);
        bit b;
        int w;
        b = m_act && (cyc - m_T) >= 1 && cyc < m_end;
        m_done = 1'b0;
        if (b) begin
            if (tr && m_ovr < 65535) m_ovr++;
            w = m_T + 2 + m_n + RD_LAT;
            if (m_end == INF && cyc >= w) begin
                if (eg) begin
                    m_end = cyc + 1; m_done = 1'b1;
                end else if (cyc == w + TIMEOUT - 1) begin
                    m_end = cyc + 1; m_terr = 1'b1;
                end
            end
        end else if (tr && en) begin
            m_act = 1'b1; m_T = cyc; m_n = ec; m_b = ub; m_end = INF; m_terr = 1'b0;
        end
    endtask

    task automatic step(input bit tr, input bit en, input bit eg, input int ec, input int ub);
        compare();
        trig = tr;
        seq_enable = en;
        dp_if.eigen_update_trig = eg;
        elem_count = 9'(ec);
        ut_base = 9'(ub);
        if (sysRst_n) m_update(tr, en, eg, ec & 511, ub & 511);
        else m_reset();
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    // Runs idle-trig cycles until the model pass has ended, strobing eigen at offset eig.
    task automatic run_pass(input int eig, input bit en, input int junk);
        for (int k = 1; k < 800; k++) begin
            step(1'b0, en, (k == eig), junk, ~junk);
            if (m_end != INF && cyc >= m_end + 2) break;
        end
    endtask

    initial begin
        dp_if.eigen_update_trig = 1'b0;
        m_reset();
        tv[0] = '{3,   'h010, 20,  4,   'h010, 'h013, 1, 0, -1};
        tv[1] = '{3,   'h1FE, 12,  4,   'h1FE, 'h001, 1, 0, -1};
        tv[2] = '{0,   'h055, 8,   1,   'h055, 'h055, 1, 0, -1};
        tv[3] = '{2,   'h100, 0,   3,   'h100, 'h102, 0, 1, 21};
        tv[4] = '{1,   'h0A0, 10,  2,   'h0A0, 'h0A1, 1, 0, -1};
        tv[5] = '{5,   'h1F0, 3,   6,   'h1F0, 'h1F5, 0, 1, 24};
        tv[6] = '{511, 'h000, 520, 512, 'h000, 'h1FF, 1, 0, -1};

        repeat (2) @(posedge sysClk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(dp_if.ut_outValid), 0);
        chk("rst_tvalid", int'(dp_if.s_ut_tvalid_t), 0);
        chk("rst_ovr", int'(overrun_cnt), 0);
        sysRst_n = 1'b1;
        obs_clear();
        step(1'b0, 1'b1, 1'b0, 0, 0);

        // Directed pass table.
        for (int i = 0; i < 7; i++) begin
            obs_clear();
            step(1'b1, 1'b1, 1'b0, tv[i].elem, tv[i].base);
            run_pass(tv[i].eig, 1'b1, ~tv[i].elem & 511);
            chk($sformatf("v%0d_beats", i), o_beats, tv[i].beats);
            chk($sformatf("v%0d_issues", i), o_a.size(), tv[i].beats);
            chk($sformatf("v%0d_tlast_cnt", i), o_tl, 1);
            chk($sformatf("v%0d_tlast_beat", i), o_tl_idx, tv[i].beats - 1);
            if (o_a.size() > 0) begin
                chk($sformatf("v%0d_addr_first", i), o_a[0], tv[i].a0);
                chk($sformatf("v%0d_addr_last", i), o_a[o_a.size()-1], tv[i].alast);
                chk($sformatf("v%0d_pos_last", i), o_p[o_p.size()-1], tv[i].beats - 1);
            end
            chk($sformatf("v%0d_done_cnt", i), o_done, tv[i].dn);
            chk($sformatf("v%0d_terr", i), int'(timeout_err), tv[i].terr);
            if (tv[i].dn != 0) chk($sformatf("v%0d_done_off", i), o_done_off, tv[i].eig + 1);
            if (tv[i].terr != 0) chk($sformatf("v%0d_terr_off", i), o_terr_off, tv[i].terr_off);
        end

        // Overrun: trigs during ISSUE and WAIT, the last coincident with completion.
        obs_clear();
        step(1'b1, 1'b1, 1'b0, 7, 'h020);
        for (int k = 1; k <= 26; k++) begin
            if (k == 20) chk("ovr_3", int'(overrun_cnt), 3);
            step((k == 2 || k == 5 || k == 15 || k == 22), 1'b1, (k == 22), 0, 0);
        end
        chk("ovr_4", int'(overrun_cnt), 4);
        chk("ovr_no_restart", int'(busy), 0);
        chk("ovr_addr_last", (o_a.size() > 0) ? o_a[o_a.size()-1] : -1, 'h027);
        chk("ovr_done_cnt", o_done, 1);

        // seq_enable gates starts only.
        step(1'b1, 1'b0, 1'b0, 3, 'h010);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("en_gate_busy", int'(busy), 0);
        obs_clear();
        step(1'b1, 1'b1, 1'b0, 4, 'h0C0);
        run_pass(9, 1'b0, 0);
        chk("en_mid_beats", o_beats, 5);
        chk("en_mid_done", o_done, 1);

        // Asynchronous reset in the middle of ISSUE.
        step(1'b1, 1'b1, 1'b0, 20, 'h033);
        repeat (4) step(1'b0, 1'b1, 1'b0, 0, 0);
        sysRst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_outValid", int'(dp_if.ut_outValid), 0);
        chk("arst_addr", int'(dp_if.ut_ramRdAddr), 0);
        chk("arst_pos", int'(dp_if.pos_rdAddr), 0);
        chk("arst_tvalid", int'(dp_if.s_ut_tvalid_t), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ovr", int'(overrun_cnt), 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        sysRst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 0, 0);
        obs_clear();
        step(1'b1, 1'b1, 1'b0, 2, 'h040);
        chk("restart_addr", int'(dp_if.ut_ramRdAddr), 'h040);
        chk("restart_pos", int'(dp_if.pos_rdAddr), 0);
        run_pass(8, 1'b1, 0);
        chk("restart_beats", o_beats, 3);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            int ec;
            ec = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 24));
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0), ec, int'($urandom_range(0, 511)));
        end
        for (int k = 0; k < 800; k++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            if (!m_act || (m_end != INF && cyc >= m_end + 2)) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ut_stream_sequencer.md
# ut_stream_sequencer

Control block that sequences one Ut-row projection pass of the eigen datapath. On each `trig` it drives the read addresses and enables of the Ut DPRAM and of the position-error buffer. It generates the aligned `tvalid`/`tlast` pair into the multiply–accumulate chain, then waits for the eigen update strobe, with a timeout and overrun accounting. It sits between the timing/trigger logic and the Ut calculation block.

## Interface
- `RD_LAT`, 1: read latency (cycles) of both Ut DPRAM port B and the error buffer.
- `TIMEOUT`, 1024: cycles allowed in WAIT before abort.
- `sysClk` in 1: system clock.
- `sysRst_n` in 1: asynchronous, active-low reset.
- `trig` in 1: start of pass, single-cycle pulse.
- `seq_enable` in 1: when 0, triggers are ignored and no pass starts.
- `elem_count` in 9: elements per pass, minus one (0 → 1 element, 511 → 512), sampled at start.
- `ut_base` in 9: Ut row base address, sampled at start.
- `eigen_update_trig` in 1: result-done strobe from the datapath.
- `ut_ramRdAddr` out 9: Ut DPRAM port-B address.
- `ut_outValid` out 1: Ut DPRAM port-B enable.
- `pos_rdAddr` out 9: error-buffer read address.
- `pos_rdEn` out 1: error-buffer read enable.
- `s_ut_tvalid_t` out 1: Ut operand valid into the multiplier.
- `posError_tvalid` out 1: error operand valid.
- `posError_tlast` out 1: last error operand.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `timeout_err` out 1: sticky; cleared by the next accepted `trig`.
- `overrun_cnt` out 16: count of `trig` pulses while busy; saturates at 0xFFFF.

## Operation
- **States:** IDLE, ISSUE, FLUSH, WAIT.
- **IDLE → ISSUE:** on `trig & seq_enable`. Latch `elem_count` into `n_last` and `ut_base` into `base`. Clear the index to 0 and clear `timeout_err`.
- **ISSUE:** one element per cycle with no gaps.
  - `ut_ramRdAddr = base + idx`, modulo 512 (wrap allowed, no error).
  - `pos_rdAddr = idx`.
  - `ut_outValid = pos_rdEn = 1`.
  - When `idx == n_last`, go to FLUSH.
- **Valid/tlast generation:** an issue-enable shift chain of depth `RD_LAT` drives the valids. `s_ut_tvalid_t` and `posError_tvalid` equal the chain output, so they are identical, cycle-aligned and contiguous for exactly `n_last+1` cycles. `posError_tlast` is the delayed "idx==n_last" flag, high only on the final valid beat.
- **FLUSH:** hold for `RD_LAT` cycles until the chain is empty, then go to WAIT. Timeout counter reset to 0.
- **WAIT:**
  - On `eigen_update_trig`: pulse `done` and return to IDLE.
  - When the counter reaches `TIMEOUT-1`: set `timeout_err` and return to IDLE with no `done`.
- **`trig` while busy:** ignored for sequencing; increments `overrun_cnt`.
- **`trig` and `eigen_update_trig` in the same WAIT cycle:** completion is taken; the trig counts as an overrun and does not start a new pass.
- **`eigen_update_trig` outside WAIT:** ignored.
- **`seq_enable` deasserted mid-pass:** the pass completes normally; `seq_enable` gates starts only.
- **Reset:** asynchronous, any state. Every output is 0, state is IDLE, `overrun_cnt` is 0. In-flight valids are dropped.

## Timing
- With `trig` high at cycle T, the first `ut_outValid` is at T+1 and the first `s_ut_tvalid_t` at T+1+`RD_LAT`.
- `posError_tlast` falls at T+1+`RD_LAT`+`n_last`.
- `busy` is high from T+1 until the cycle after `done` or the timeout; it is low in IDLE.
- Minimum `trig` spacing for no overrun is `n_last + RD_LAT + 2 + datapath latency` cycles.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Shared package `fofb_seq_pkg`:
  - state enum `seq_state_t`
  - `UT_AW` = 9
  - `OVR_W` = 16
- No sub-modules.
- Timeout counter width is `$clog2(TIMEOUT)`.

## Test plan
- **Basic pass:** `RD_LAT`=1, `elem_count`=3, `ut_base`=0x010, trig at T, `eigen_update_trig` at T+20.
  - Addresses 0x010–0x013 on T+1..T+4.
  - Valids on T+2..T+5, tlast only on T+5.
  - `done` at T+21.
- **Wrap:** `ut_base`=0x1FE, `elem_count`=3 → Ut addresses 0x1FE, 0x1FF, 0x000, 0x001; `pos_rdAddr` 0..3.
- **Single element:** `elem_count`=0 → one valid beat, with tlast on that beat.
- **Timeout:** `TIMEOUT`=16, no `eigen_update_trig`.
  - `timeout_err`=1 exactly 16 cycles after entering WAIT; no `done`.
  - The next trig clears it.
- **Overrun:** 3 trigs during ISSUE/WAIT → `overrun_cnt`=3 and the addresses are unaffected.
- **Async reset mid-ISSUE** (deasserted off-edge): all outputs 0 immediately, IDLE; the next trig restarts from idx 0.
